// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NUM_REQ valid/ready producers
// take turns writing bursts of up to MAX_BURST words into a sync FIFO.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_req_valid       per-requester valid
//   i_req_data        requester i word at [i*WIDTH +: WIDTH]
//   o_req_ready       per-requester accept strobe (owner only)
//   i_fifo_full       FIFO full flag, honoured in the same cycle
//   o_fifo_wr_en      FIFO write enable
//   o_fifo_wr_data    FIFO write data (owner's word)
//   o_grant_valid     a requester currently owns the write port
//   o_grant_id        index of that owner
module fifo_wr_arbiter #(
   parameter int WIDTH     = 32,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]       o_req_ready,
   input  logic                     i_fifo_full,
   output logic                     o_fifo_wr_en,
   output logic [WIDTH-1:0]         o_fifo_wr_data,
   output logic                     o_grant_valid,
   output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int BW  = $clog2(MAX_BURST + 1);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]     r_state;
   logic [IDW-1:0] r_owner;
   logic [IDW-1:0] r_last;
   logic [BW-1:0]  r_beat;
   logic [IDW-1:0] w_sel;
   logic           w_grant;
   logic           w_xfer;

   // Scan from the farthest offset down so the nearest requester after
   // r_last is the one left in w_sel.
   always_comb begin
      w_sel = '0;
      for (int k = NUM_REQ; k >= 1; k--)
         if (i_req_valid[(int'(r_last) + k) % NUM_REQ])
            w_sel = IDW'((int'(r_last) + k) % NUM_REQ);
   end

   assign w_grant        = r_state == S_GRANT;
   assign w_xfer         = w_grant & i_req_valid[r_owner] & ~i_fifo_full;
   assign o_fifo_wr_en   = w_xfer;
   assign o_fifo_wr_data = i_req_data[r_owner*WIDTH +: WIDTH];
   assign o_grant_valid  = w_grant;
   assign o_grant_id     = w_grant ? r_owner : '0;

   always_comb begin
      o_req_ready = '0;
      o_req_ready[r_owner] = w_grant & ~i_fifo_full;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_owner <= '0;
         r_last  <= IDW'(NUM_REQ - 1);
         r_beat  <= '0;
      end else if (r_state == S_IDLE) begin
         if (|i_req_valid) begin
            r_owner <= w_sel;
            r_last  <= w_sel;
            r_beat  <= '0;
            r_state <= S_GRANT;
         end
      end else if (!i_req_valid[r_owner]) begin
         r_state <= S_IDLE;
      end else if (w_xfer) begin
         r_beat <= r_beat + BW'(1);
         if (r_beat == BW'(MAX_BURST - 1))
            r_state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus reset and FIFO integration sequences.
module tb_fifo_wr_arbiter;
   localparam int W = 32;
   localparam int N = 4;

   typedef struct {
      logic [3:0]  v;
      logic        f;
      logic        we;
      logic [3:0]  rdy;
      logic        gv;
      logic [1:0]  gid;
      logic [31:0] d;
   } vec_t;

   logic         clk = 0;
   logic         rst_n = 0;
   logic [N-1:0] tb_v = '0;
   logic         tb_f = 0;
   logic         integ = 0;
   logic         qfull = 0;
   logic [N-1:0] v;
   logic [N*W-1:0] rd;
   logic         f;
   logic [N-1:0] rdy;
   logic         we;
   logic [W-1:0] wd;
   logic         gv;
   logic [1:0]   gid;
   int           cnt[N];
   int           n_cmp = 0;
   int           n_bad = 0;
   vec_t         tbl[$];

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v), .i_req_data(rd),
      .o_req_ready(rdy), .i_fifo_full(f), .o_fifo_wr_en(we),
      .o_fifo_wr_data(wd), .o_grant_valid(gv), .o_grant_id(gid)
   );

   // Producer i offers {i, sequence number} words, advancing on accept.
   always_comb begin
      v = tb_v;
      for (int i = 0; i < N; i++) begin
         if (integ) v[i] = cnt[i] < 18;
         rd[i*W +: W] = W'((i << 8) | (cnt[i] + 1));
      end
   end
   assign f = integ ? qfull : tb_f;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) for (int i = 0; i < N; i++) cnt[i] <= 0;
      else for (int i = 0; i < N; i++) if (v[i] & rdy[i]) cnt[i] <= cnt[i] + 1;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   task automatic add(input logic [3:0] v_, input logic f_, input logic we_, input logic [3:0] r_,
                      input logic gv_, input logic [1:0] g_, input logic [31:0] d_);
      vec_t x;
      x.v = v_; x.f = f_; x.we = we_; x.rdy = r_; x.gv = gv_; x.gid = g_; x.d = d_;
      tbl.push_back(x);
   endtask

   task automatic idle(input logic [3:0] v_);
      add(v_, 0, 0, 4'b0000, 0, 0, 0);
   endtask

   task automatic beats(input logic [3:0] v_, input logic [1:0] g_, input int first, input int n);
      for (int b = 0; b < n; b++) add(v_, 0, 1, 4'b0001 << g_, 1, g_, 32'(first + b));
   endtask

   logic [W-1:0] q[$];
   int           expn[N];
   int           popped = 0;
   int           cyc = 0;
   logic         saw_full = 0;
   logic         push, pop;
   logic [W-1:0] wdat, dq;

   initial begin
      idle(4'b0001);
      beats(4'b0001, 0, 1, 4);
      idle(4'b0001);
      beats(4'b0001, 0, 5, 4);
      idle(4'b1111);
      beats(4'b1111, 1, 'h101, 4);
      idle(4'b1111);
      beats(4'b0100, 2, 'h201, 2);
      for (int i = 0; i < 3; i++) add(4'b1111, 1, 0, 4'b0000, 1, 2, 0);
      beats(4'b1111, 2, 'h203, 2);
      idle(4'b1111);
      beats(4'b1111, 3, 'h301, 1);
      beats(4'b1001, 3, 'h302, 2);
      beats(4'b1111, 3, 'h304, 1);
      idle(4'b1111);
      beats(4'b1111, 0, 9, 4);
      idle(4'b1111);
      beats(4'b1111, 1, 'h105, 1);
      add(4'b1000, 0, 0, 4'b0010, 1, 1, 0);
      idle(4'b1000);
      beats(4'b1000, 3, 'h305, 1);
      add(4'b0000, 1, 0, 4'b0000, 1, 3, 0);
      idle(4'b0000);

      repeat (2) @(negedge clk);
      rst_n = 1;
      foreach (tbl[r]) begin
         tb_v = tbl[r].v;
         tb_f = tbl[r].f;
         #1;
         chk($sformatf("r%0d_wr_en", r), 32'(we), 32'(tbl[r].we));
         chk($sformatf("r%0d_ready", r), 32'(rdy), 32'(tbl[r].rdy));
         chk($sformatf("r%0d_gvalid", r), 32'(gv), 32'(tbl[r].gv));
         chk($sformatf("r%0d_gid", r), 32'(gid), 32'(tbl[r].gid));
         if (tbl[r].we) chk($sformatf("r%0d_data", r), wd, tbl[r].d);
         @(negedge clk);
      end

      tb_v = 4'b0100;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_pre_gvalid", 32'(gv), 1);
      chk("rst_pre_gid", 32'(gid), 2);
      #2 rst_n = 0;
      #1;
      chk("rst_async_wr_en", 32'(we), 0);
      chk("rst_async_ready", 32'(rdy), 0);
      chk("rst_async_gvalid", 32'(gv), 0);
      @(negedge clk);
      rst_n = 1;
      tb_v = 4'b1111;
      #1;
      chk("rst_idle_gvalid", 32'(gv), 0);
      @(negedge clk);
      #1;
      chk("rst_prio_gvalid", 32'(gv), 1);
      chk("rst_prio_gid", 32'(gid), 0);

      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      integ = 1;
      while (popped < 72 && cyc < 3000) begin
         #1;
         if (we) begin
            chk("int_wr_when_full", 32'(f), 0);
            chk("int_tag_is_owner", 32'(wd[15:8]), 32'(gid));
         end
         push = we;
         wdat = wd;
         pop = (cyc % 3 == 0) && (q.size() > 0);
         @(posedge clk);
         #1;
         if (pop) begin
            dq = q.pop_front();
            if (dq[15:8] < N) begin
               chk($sformatf("int_seq_req%0d", dq[15:8]), 32'(dq[7:0]), 32'(expn[dq[15:8]] + 1));
               expn[dq[15:8]]++;
            end else chk("int_tag_range", 32'(dq[15:8]), 0);
            popped++;
         end
         if (push) q.push_back(wdat);
         qfull = q.size() >= 16;
         if (qfull) saw_full = 1;
         cyc++;
         @(negedge clk);
      end
      chk("int_words_drained", 32'(popped), 72);
      chk("int_full_seen", 32'(saw_full), 1);
      chk("int_fifo_empty", 32'(q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
